// File: rtl/motoro3_pwm_capture_if.sv
// Result bus between the PWM capture block and the step/loss logic.
// The master drives per-pulse and per-window results; the slave returns capReady.
interface motoro3_pwm_capture_if #(
   parameter int CNT_W = 16
);
   logic             capValid;
   logic             capReady;
   logic [CNT_W-1:0] capHigh;
   logic [CNT_W-1:0] capPeriod;
   logic             winDone;
   logic [CNT_W-1:0] capWinHigh;
   logic [7:0]       capPulses;
   logic [3:0]       capStep;

   modport master (
      output capValid, capHigh, capPeriod, winDone, capWinHigh, capPulses, capStep,
      input  capReady
   );

   modport slave (
      input  capValid, capHigh, capPeriod, winDone, capWinHigh, capPulses, capStep,
      output capReady
   );
endinterface

// File: rtl/motoro3_pwm_capture.sv
// Recovers high time, period and per-step window totals from the sensed PWM of one phase.
// Optional input glitch filter: define MOTORO3_PWM_CAP_GLITCH_EN.
module motoro3_pwm_capture #(
   parameter int CNT_W      = 16,
   parameter int MIN_PULSE  = 32,
   parameter int TIMEOUT    = 4095,
   parameter int GLITCH_LEN = 4
) (
   input  logic                         clk,
   input  logic                         nRst,
   input  logic                         pwmIn_i,
   input  logic                         capEnable_i,
   input  logic                         winStrobe_i,
   input  logic [3:0]                   sgStep_i,
   motoro3_pwm_capture_if.master        capBus,
   output logic                         errGlitch_o,
   output logic                         errTimeout_o,
   output logic                         errOverrun_o
);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] MIN_PULSE_C = CNT_W'(MIN_PULSE);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

   if (GLITCH_LEN < 1 || TIMEOUT < 1) begin : gBadParams
      $error("motoro3_pwm_capture: GLITCH_LEN and TIMEOUT must be at least 1");
   end

   logic sync1_q, sync2_q, dPrev_q;
   logic d, rise, fall;

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dPrev_q <= 1'b0;
      end else begin
         sync1_q <= pwmIn_i;
         sync2_q <= sync1_q;
         dPrev_q <= d;
      end
   end

`ifdef MOTORO3_PWM_CAP_GLITCH_EN
   localparam int FW = $clog2(GLITCH_LEN + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(GLITCH_LEN - 1);

   logic          filt_q;
   logic [FW-1:0] filtCnt_q;

   // The filtered level only moves after GLITCH_LEN consecutive disagreeing samples.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         filt_q    <= 1'b0;
         filtCnt_q <= '0;
      end else if (sync2_q == filt_q) begin
         filtCnt_q <= '0;
      end else if (filtCnt_q == FILT_LAST) begin
         filt_q    <= sync2_q;
         filtCnt_q <= '0;
      end else begin
         filtCnt_q <= filtCnt_q + 1'b1;
      end
   end

   assign d = filt_q;
`else
   assign d = sync2_q;
`endif

   assign rise = d & ~dPrev_q;
   assign fall = ~d & dPrev_q;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t           state_q;
   logic [CNT_W-1:0] perCnt_q, hiCnt_q, idleCnt_q, winAcc_q;
   logic [7:0]       pulseCnt_q;
   logic             capValid_q, winDone_q;
   logic [CNT_W-1:0] capHigh_q, capPeriod_q, capWinHigh_q;
   logic [7:0]       capPulses_q;
   logic [3:0]       capStep_q;
   logic             errGlitch_q, errTimeout_q, errOverrun_q;
   logic             timeoutHit, emit, xfer;
   logic [7:0]       pulseInc;

   assign timeoutHit = (state_q != IDLE) && (idleCnt_q == TIMEOUT_C);
   assign emit       = (state_q == LOW) && rise && !timeoutHit;
   assign xfer       = capValid_q && capBus.capReady;
   assign pulseInc   = (rise && !(&pulseCnt_q)) ? pulseCnt_q + 8'd1 : pulseCnt_q;

   // Timeout wins over any edge seen at the same cycle; the window keeps running regardless.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         perCnt_q     <= '0;
         hiCnt_q      <= '0;
         idleCnt_q    <= '0;
         winAcc_q     <= '0;
         pulseCnt_q   <= '0;
         capValid_q   <= 1'b0;
         capHigh_q    <= '0;
         capPeriod_q  <= '0;
         winDone_q    <= 1'b0;
         capWinHigh_q <= '0;
         capPulses_q  <= '0;
         capStep_q    <= '0;
         errGlitch_q  <= 1'b0;
         errTimeout_q <= 1'b0;
         errOverrun_q <= 1'b0;
      end else if (!capEnable_i) begin
         state_q      <= IDLE;
         perCnt_q     <= '0;
         hiCnt_q      <= '0;
         idleCnt_q    <= '0;
         winAcc_q     <= '0;
         pulseCnt_q   <= '0;
         capValid_q   <= 1'b0;
         winDone_q    <= 1'b0;
         errGlitch_q  <= 1'b0;
         errTimeout_q <= 1'b0;
         errOverrun_q <= 1'b0;
      end else begin
         winDone_q <= 1'b0;
         if (state_q == IDLE) begin
            state_q <= WAIT_RISE;
         end else begin
            if (winStrobe_i) begin
               capWinHigh_q <= d ? satInc(winAcc_q) : winAcc_q;
               capPulses_q  <= pulseInc;
               capStep_q    <= sgStep_i;
               winAcc_q     <= '0;
               pulseCnt_q   <= '0;
               winDone_q    <= 1'b1;
            end else begin
               winAcc_q   <= d ? satInc(winAcc_q) : winAcc_q;
               pulseCnt_q <= pulseInc;
            end

            if (timeoutHit) begin
               errTimeout_q <= 1'b1;
               state_q      <= WAIT_RISE;
               perCnt_q     <= '0;
               hiCnt_q      <= '0;
               idleCnt_q    <= '0;
            end else begin
               perCnt_q  <= rise ? ONE_C : satInc(perCnt_q);
               hiCnt_q   <= rise ? ONE_C : (d ? satInc(hiCnt_q) : hiCnt_q);
               idleCnt_q <= (rise || fall) ? '0 : satInc(idleCnt_q);
               case (state_q)
                  WAIT_RISE: if (rise) state_q <= HIGH;
                  HIGH: if (fall) begin
                     state_q <= LOW;
                     if (hiCnt_q < MIN_PULSE_C) errGlitch_q <= 1'b1;
                  end
                  LOW: if (rise) state_q <= HIGH;
                  default: state_q <= IDLE;
               endcase
            end
         end

         if (emit) begin
            if (!capValid_q || capBus.capReady) begin
               capHigh_q   <= hiCnt_q;
               capPeriod_q <= perCnt_q;
               capValid_q  <= 1'b1;
            end else begin
               errOverrun_q <= 1'b1;
            end
         end else if (xfer) begin
            capValid_q <= 1'b0;
         end
      end
   end

   assign capBus.capValid   = capValid_q;
   assign capBus.capHigh    = capHigh_q;
   assign capBus.capPeriod  = capPeriod_q;
   assign capBus.winDone    = winDone_q;
   assign capBus.capWinHigh = capWinHigh_q;
   assign capBus.capPulses  = capPulses_q;
   assign capBus.capStep    = capStep_q;
   assign errGlitch_o       = errGlitch_q;
   assign errTimeout_o      = errTimeout_q;
   assign errOverrun_o      = errOverrun_q;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Scoreboard bench for motoro3_pwm_capture (default build, glitch filter not compiled in).
`timescale 1ns/1ps
module tb_motoro3_pwm_capture;

   typedef struct {int hi; int per;} capExp_t;
   typedef struct {int wh; int pc; int st;} winExp_t;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       pwmIn = 1'b0;
   logic       capEnable = 1'b0;
   logic       winStrobe = 1'b0;
   logic [3:0] sgStep = 4'd0;
   logic       errGlitch, errTimeout, errOverrun;

   motoro3_pwm_capture_if #(.CNT_W(16)) capBus ();

   motoro3_pwm_capture #(
      .CNT_W(16), .MIN_PULSE(32), .TIMEOUT(4095), .GLITCH_LEN(4)
   ) dut (
      .clk          (clk),
      .nRst         (nRst),
      .pwmIn_i      (pwmIn),
      .capEnable_i  (capEnable),
      .winStrobe_i  (winStrobe),
      .sgStep_i     (sgStep),
      .capBus       (capBus.master),
      .errGlitch_o  (errGlitch),
      .errTimeout_o (errTimeout),
      .errOverrun_o (errOverrun)
   );

   always #50 clk = ~clk;

   int      checks = 0;
   int      errors = 0;
   capExp_t capQ[$];
   winExp_t winQ[$];
   int      lastHi = 0, lastPer = 0;
   bit      havePrev = 1'b0;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   // One PWM period; the previous period's result is expected at this period's rise.
   task automatic applyStimulus(input int hi, input int lo, input bit doPush);
      if (havePrev && doPush) capQ.push_back('{lastHi, lastPer});
      for (int i = 0; i < hi; i++) begin @(posedge clk); pwmIn = 1'b1; end
      for (int i = 0; i < lo; i++) begin @(posedge clk); pwmIn = 1'b0; end
      lastHi = hi;
      lastPer = hi + lo;
      havePrev = 1'b1;
   endtask

   task automatic goIdle();
      @(posedge clk);
      pwmIn = 1'b0;
      capEnable = 1'b0;
      tick(4);
      @(posedge clk);
      capEnable = 1'b1;
      havePrev = 1'b0;
      tick(2);
   endtask

   // Outputs change on the falling edge, so the monitor looks just after the rising edge.
   initial begin
      capExp_t ce;
      winExp_t we;
      forever begin
         @(posedge clk);
         #1;
         if (capBus.capValid && capBus.capReady) begin
            checkOutput("capExpected", int'(capQ.size() != 0), 1);
            if (capQ.size() != 0) begin
               ce = capQ.pop_front();
               checkOutput("capHigh", int'(capBus.capHigh), ce.hi);
               checkOutput("capPeriod", int'(capBus.capPeriod), ce.per);
            end
         end
         if (capBus.winDone) begin
            checkOutput("winExpected", int'(winQ.size() != 0), 1);
            if (winQ.size() != 0) begin
               we = winQ.pop_front();
               checkOutput("capWinHigh", int'(capBus.capWinHigh), we.wh);
               checkOutput("capPulses", int'(capBus.capPulses), we.pc);
               checkOutput("capStep", int'(capBus.capStep), we.st);
            end
         end
      end
   end

   initial begin
      int  wa, pc;
      bit  h1, h2, h3, dm, dpm, rs;

      capBus.capReady = 1'b0;
      tick(3);
      #1;
      checkOutput("rstCapValid", int'(capBus.capValid), 0);
      checkOutput("rstCapHigh", int'(capBus.capHigh), 0);
      checkOutput("rstCapPeriod", int'(capBus.capPeriod), 0);
      checkOutput("rstWinDone", int'(capBus.winDone), 0);
      checkOutput("rstCapWinHigh", int'(capBus.capWinHigh), 0);
      checkOutput("rstCapPulses", int'(capBus.capPulses), 0);
      checkOutput("rstCapStep", int'(capBus.capStep), 0);
      checkOutput("rstErrGlitch", int'(errGlitch), 0);
      checkOutput("rstErrTimeout", int'(errTimeout), 0);
      checkOutput("rstErrOverrun", int'(errOverrun), 0);
      @(posedge clk);
      nRst = 1'b1;

      $display("[TB] steady PWM 100/300");
      capBus.capReady = 1'b1;
      goIdle();
      for (int k = 0; k < 6; k++) applyStimulus(100, 300, 1'b1);
      #1;
      checkOutput("steadyErrGlitch", int'(errGlitch), 0);
      checkOutput("steadyErrTimeout", int'(errTimeout), 0);
      checkOutput("steadyErrOverrun", int'(errOverrun), 0);
      checkOutput("steadyQueueEmpty", capQ.size(), 0);

      $display("[TB] short pulse 20/380");
      goIdle();
      applyStimulus(100, 300, 1'b1);
      #1;
      checkOutput("shortErrGlitchBefore", int'(errGlitch), 0);
      applyStimulus(20, 380, 1'b1);
      #1;
      checkOutput("shortErrGlitchAfter", int'(errGlitch), 1);
      applyStimulus(100, 300, 1'b1);
      applyStimulus(100, 300, 1'b1);
      checkOutput("shortQueueEmpty", capQ.size(), 0);

      $display("[TB] timeout");
      goIdle();
      applyStimulus(100, 300, 1'b1);
      tick(3700);
      #1;
      checkOutput("timeoutNotYet", int'(errTimeout), 0);
      tick(1000);
      #1;
      checkOutput("timeoutSet", int'(errTimeout), 1);
      havePrev = 1'b0;
      applyStimulus(100, 300, 1'b1);
      applyStimulus(100, 300, 1'b1);
      checkOutput("timeoutQueueEmpty", capQ.size(), 0);

      $display("[TB] overrun");
      goIdle();
      capBus.capReady = 1'b0;
      applyStimulus(50, 200, 1'b1);
      applyStimulus(50, 200, 1'b1);
      applyStimulus(50, 200, 1'b0);
      #1;
      checkOutput("overrunValidHeld", int'(capBus.capValid), 1);
      checkOutput("overrunErr", int'(errOverrun), 1);
      @(posedge clk);
      capBus.capReady = 1'b1;
      tick(3);
      #1;
      checkOutput("overrunValidCleared", int'(capBus.capValid), 0);
      checkOutput("overrunQueueEmpty", capQ.size(), 0);

      $display("[TB] window 50/200, strobes incl. one on a rise");
      @(posedge clk);
      pwmIn = 1'b0;
      capEnable = 1'b0;
      sgStep = 4'd7;
      tick(4);
      wa = 0; pc = 0; h1 = 0; h2 = 0; h3 = 0;
      for (int c = 0; c < 4100; c++) begin
         @(posedge clk);
         capEnable = 1'b1;
         pwmIn = ((c % 250) < 50);
         winStrobe = (c == 1000 || c == 2002 || c == 3000 || c == 4000);
         if ((c % 250) == 0 && c > 0) capQ.push_back('{50, 250});
         dm = h2;
         dpm = h3;
         rs = dm & ~dpm;
         if (c >= 1) begin
            if (winStrobe) begin
               winQ.push_back('{wa + int'(dm), pc + int'(rs), 7});
               wa = 0;
               pc = 0;
            end else begin
               wa += int'(dm);
               pc += int'(rs);
            end
         end
         h3 = h2;
         h2 = h1;
         h1 = pwmIn;
      end
      @(posedge clk);
      winStrobe = 1'b0;
      tick(5);
      checkOutput("winQueueEmpty", winQ.size(), 0);
      checkOutput("winCapQueueEmpty", capQ.size(), 0);

      $display("[TB] disable mid-high, then reset");
      capBus.capReady = 1'b0;
      goIdle();
      applyStimulus(20, 200, 1'b0);
      applyStimulus(20, 200, 1'b0);
      @(posedge clk);
      pwmIn = 1'b1;
      tick(30);
      #1;
      checkOutput("disValidBefore", int'(capBus.capValid), 1);
      checkOutput("disGlitchBefore", int'(errGlitch), 1);
      @(posedge clk);
      capEnable = 1'b0;
      tick(2);
      #1;
      checkOutput("disValidCleared", int'(capBus.capValid), 0);
      checkOutput("disGlitchCleared", int'(errGlitch), 0);
      checkOutput("disOverrunCleared", int'(errOverrun), 0);
      checkOutput("disCapHighHeld", int'(capBus.capHigh), 20);
      checkOutput("disCapPeriodHeld", int'(capBus.capPeriod), 220);
      checkOutput("disCapStepHeld", int'(capBus.capStep), 7);
      @(posedge clk);
      nRst = 1'b0;
      #1;
      checkOutput("nRstCapHigh", int'(capBus.capHigh), 0);
      checkOutput("nRstCapPeriod", int'(capBus.capPeriod), 0);
      checkOutput("nRstCapWinHigh", int'(capBus.capWinHigh), 0);
      checkOutput("nRstCapPulses", int'(capBus.capPulses), 0);
      checkOutput("nRstCapStep", int'(capBus.capStep), 0);
      checkOutput("nRstCapValid", int'(capBus.capValid), 0);
      @(posedge clk);
      nRst = 1'b1;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motoro3_pwm_capture.md
# motoro3_pwm_capture

Measures a PWM waveform coming back from the gate-drive/MOS sense path and reports per-pulse high time, period and per-step window totals. It is the receive-side counterpart of the motoro3 PWM generator: the generator produces pulses from wanted position counts, and this block recovers the real high-cycle counts so control logic can compare wanted against delivered. It sits per phase, runs on the 10 MHz system clock, and hands results to the step/loss logic through a valid/ready handshake.

## Interface
- CNT_W, 16: width of high, period and window counters.
- MIN_PULSE, 32: shortest legal high pulse in clk cycles. 3.2 µs is the MOS driver minimum.
- TIMEOUT, 4095: cycles without any edge before timeout.
- GLITCH_LEN, 4: filter length. Used only with the glitch filter compiled in.

- clk  in  1  10 MHz system clock. All registers update on the falling edge.
- nRst  in  1  reset, asynchronous, active-low.
- pwmIn  in  1  asynchronous PWM sense input.
- capEnable  in  1  level. Low forces the block idle and clears all state.
- winStrobe  in  1  one-cycle step-boundary pulse that closes the accumulation window.
- sgStep  in  4  current commutation step, captured at winStrobe.
- capReady  in  1  consumer accepts the pulse result.
- capValid  out  1  pulse result available.
- capHigh  out  CNT_W  high cycles of the last complete period.
- capPeriod  out  CNT_W  rise-to-rise cycles of the last complete period.
- winDone  out  1  one-cycle pulse; the window outputs below were updated.
- capWinHigh  out  CNT_W  total high cycles in the closed window.
- capPulses  out  8  rising edges counted in the closed window.
- capStep  out  4  sgStep value captured at window close.
- errGlitch  out  1  sticky. A high pulse was shorter than MIN_PULSE.
- errTimeout  out  1  sticky. No edge was seen for TIMEOUT cycles.
- errOverrun  out  1  sticky. A result was dropped while capValid was high and capReady was low.

## Operation
**Input conditioning**
- pwmIn passes through a 2-flop synchronizer to produce d.
- With the glitch filter compiled in, d is filtered first (see Configuration).
- dPrev is d from the previous cycle.
- rise = d & !dPrev. fall = !d & dPrev.

**States:** IDLE, WAIT_RISE, HIGH, LOW.
- IDLE → WAIT_RISE when capEnable is high.
- Any state → IDLE when capEnable is low. This clears:
  - counters, window accumulators and the state register;
  - capValid and all error flags.
- capHigh, capPeriod and the window outputs hold their last values.
- WAIT_RISE → HIGH on rise. Nothing is emitted, because there is no prior period.
- HIGH → LOW on fall.
  - If hiCnt < MIN_PULSE, set errGlitch. The pulse is still measured.
- LOW → HIGH on rise. The block emits a result: capHigh ← hiCnt, capPeriod ← perCnt.

**Counters**
- perCnt: loads 1 on rise, otherwise increments.
- hiCnt: loads 1 on rise, increments while d = 1, holds while d = 0.
- All counters saturate at all-ones and never wrap.

**Timeout**
- idleCnt clears on any edge and otherwise increments.
- When idleCnt reaches TIMEOUT in WAIT_RISE, HIGH or LOW:
  - set errTimeout;
  - go to WAIT_RISE and clear perCnt, hiCnt and idleCnt.

**Handshake**
- A transfer occurs at an edge where capValid & capReady.
- Emit with no pending result, or with a transfer at the same edge: load the outputs and set capValid = 1.
- Emit while capValid & !capReady: keep the old data, drop the new result, set errOverrun.
- Transfer with no emit: capValid ← 0.

**Window**
- winAcc increments while d = 1.
- pulseCnt increments on rise. It saturates at 255.
- On winStrobe in a non-IDLE state:
  - capWinHigh ← winAcc + d (saturated);
  - capPulses ← pulseCnt + rise;
  - capStep ← sgStep;
  - winAcc ← 0 and pulseCnt ← 0;
  - winDone = 1 for one cycle.
- winStrobe in IDLE is ignored.

## Timing
- Reset values: every output 0, state IDLE.
- Latency from a pwmIn edge to d: 2 clk. With the glitch filter compiled in: 2 + GLITCH_LEN. Measured widths are unchanged by this latency.
- capValid, capHigh and capPeriod update at the same edge as the rise detection. There is no extra pipeline stage.
- winDone and the window outputs update at the winStrobe edge.
- Simultaneous winStrobe and rise: both act. The rise counts in the closing window and starts the next period normally.
- capEnable deasserted mid-pulse: IDLE at the next edge. The partial period is discarded.
- nRst may assert at any time and takes effect immediately (asynchronous).

## Configuration
- Macro MOTORO3_PWM_CAP_GLITCH_EN.
- Defined: the filtered level follows the synchronized input only after the input has differed from it for GLITCH_LEN consecutive cycles. Pulses shorter than GLITCH_LEN cycles are removed.
- Undefined: d is the synchronizer output directly, and GLITCH_LEN is unused.

## Test plan
- **Steady PWM:** pwmIn high 100, low 300, repeated, capReady = 1.
  - From the second rise onward: capHigh = 100 and capPeriod = 400 on every period, with no error flags.
- **Short pulse:** one high pulse of 20 cycles in a 400-cycle period, macro undefined.
  - errGlitch = 1 and capHigh = 20.
  - The same pulse of 2 cycles with the macro defined is filtered out and merges into the surrounding period.
- **Timeout:** pwmIn held low for 5000 cycles after a pulse.
  - errTimeout sets at idleCnt = 4095 and the state returns to WAIT_RISE.
  - The next two rises produce one valid result.
- **Overrun:** capReady = 0 across three periods of 50/200.
  - The first result is held and errOverrun = 1.
  - After capReady = 1, the held result transfers once.
- **Window:** winStrobe every 1000 cycles with 50/200 PWM and sgStep = 7.
  - Each winDone gives capWinHigh ≈ 200 (four pulses, ±50 at the boundaries), capPulses = 4 or 5, capStep = 7.
  - Strobe coincident with a rise counts that rise.
- **Disable/reset:** deassert capEnable mid-high, then pulse nRst low.
  - capValid = 0 and the flags clear.
  - Outputs are all 0 after nRst.
